pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_stall_enc.sv | 26 ++
 rtl/pipe_ctrl.sv | 91 +++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline control unit
package pipe_ctrl_pkg;

  // FSM encodings; FREEZE is reserved and decodes as RUN
  typedef enum logic [1:0] {
    PCTRL_RUN    = 2'd0,
    PCTRL_FREEZE = 2'd1,
    PCTRL_FLUSH  = 2'd2
  } pctrl_state_e;

  // Stall vector constants, bit order {wb, mem, ex, id, if, pc}
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
  localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;
  localparam logic [5:0] STALL_ALL      = 6'b111111;

  // Exception codes presented by the MEM/CP0 stage
  localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  // ERET returns to EPC; every other code (known or not) enters the handler
  function automatic logic [31:0] handler_pc(input logic [31:0] exc,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// rtl/pipe_ctrl_stall_enc.sv - priority encoder from stage stall requests to stall vector
module pipe_ctrl_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] stall_o
);

  // Later stage wins: a stall deeper in the pipe must freeze everything upstream
  always_comb begin
    stall_o = STALL_NONE;
    if (req_mem_i) begin
      stall_o = STALL_FROM_MEM;
    end else if (req_ex_i) begin
      stall_o = STALL_FROM_EX;
    end else if (req_id_i) begin
      stall_o = STALL_FROM_ID;
    end else if (req_if_i) begin
      stall_o = STALL_FROM_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush producer; optional stall counter under PIPE_CTRL_STALL_CNT_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
`ifdef PIPE_CTRL_STALL_CNT_EN
  output logic [31:0] stall_cycles_o,
`endif
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc
);

  pctrl_state_e state_q, state_d;
  logic [31:0]  new_pc_q, new_pc_d;
  logic [5:0]   req_stall;

  pipe_ctrl_stall_enc u_stall_enc (
    .req_if_i  (stallreq_from_if),
    .req_id_i  (stallreq_from_id),
    .req_ex_i  (stallreq_from_ex),
    .req_mem_i (stallreq_from_mem),
    .stall_o   (req_stall)
  );

  // State and handler address registers; reset aborts any freeze/flush in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PCTRL_RUN;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state and outputs; outputs are forced quiet while reset is held
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = 32'h0;
    case (state_q)
      PCTRL_FLUSH: begin
        flush   = 1'b1;
        new_pc  = new_pc_q;
        state_d = PCTRL_RUN;
      end
      default: begin
        if (excepttype_i != EXC_NONE) begin
          stall    = STALL_ALL;
          new_pc_d = handler_pc(excepttype_i, cp0_epc_i, EXC_VECTOR);
          state_d  = PCTRL_FLUSH;
        end else begin
          stall = req_stall;
        end
      end
    endcase
    if (rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = 32'h0;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held, freeze cycle included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if (stall[0] && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] m_cnt;
`endif

  int total = 0;
  int bad   = 0;

  bit          m_flush;
  logic [31:0] m_pc;

  typedef struct {
    logic [3:0] req;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .stall_cycles_o    (stall_cycles),
`endif
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp_v);
    end
  endtask

  // Number of frozen low bits is one more than the depth of the deepest requester
  function automatic logic [5:0] ref_stall(input logic [3:0] r);
    int lvl;
    lvl = r[3] ? 4 : r[2] ? 3 : r[1] ? 2 : r[0] ? 1 : 0;
    if (lvl == 0) return 6'd0;
    return 6'((7'd1 << (lvl + 1)) - 7'd1);
  endfunction

  task automatic set_req(input logic [3:0] r);
    {req_mem, req_ex, req_id, req_if} = r;
  endtask

  task automatic model_reset();
    m_flush = 1'b0;
    m_pc    = 32'h0;
`ifdef PIPE_CTRL_STALL_CNT_EN
    m_cnt   = 32'h0;
`endif
  endtask

  task automatic expect_now(input string tag);
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    if (m_flush) begin
      es = 6'd0; ef = 1'b1; ep = m_pc;
    end else if (exc != 32'h0) begin
      es = 6'h3f; ef = 1'b0; ep = 32'h0;
    end else begin
      es = ref_stall({req_mem, req_ex, req_id, req_if}); ef = 1'b0; ep = 32'h0;
    end
    check({tag, ".stall"}, 32'(stall), 32'(es));
    check({tag, ".flush"}, 32'(flush), 32'(ef));
    check({tag, ".new_pc"}, new_pc, ep);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check({tag, ".cnt"}, stall_cycles, m_cnt);
`endif
  endtask

  // Clock edge plus model update from the inputs present at that edge
  task automatic advance();
    bit was_flush;
    was_flush = m_flush;
    @(posedge clk);
`ifdef PIPE_CTRL_STALL_CNT_EN
    if (!was_flush && (exc != 32'h0 || {req_mem, req_ex, req_id, req_if} != 4'h0) &&
        m_cnt != 32'hFFFF_FFFF)
      m_cnt = m_cnt + 1;
`endif
    if (was_flush) begin
      m_flush = 1'b0;
    end else if (exc != 32'h0) begin
      m_flush = 1'b1;
      m_pc    = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
    end
    #1;
  endtask

  initial begin
    logic [31:0] codes [7];
    codes[0] = 32'h01; codes[1] = 32'h08; codes[2] = 32'h0a; codes[3] = 32'h0c;
    codes[4] = 32'h0d; codes[5] = 32'h0e; codes[6] = 32'h55;

    vecs[0]  = '{4'h0, 6'h00}; vecs[1]  = '{4'h1, 6'h03};
    vecs[2]  = '{4'h2, 6'h07}; vecs[3]  = '{4'h3, 6'h07};
    vecs[4]  = '{4'h4, 6'h0f}; vecs[5]  = '{4'h5, 6'h0f};
    vecs[6]  = '{4'h6, 6'h0f}; vecs[7]  = '{4'h7, 6'h0f};
    vecs[8]  = '{4'h8, 6'h1f}; vecs[9]  = '{4'h9, 6'h1f};
    vecs[10] = '{4'ha, 6'h1f}; vecs[11] = '{4'hb, 6'h1f};
    vecs[12] = '{4'hc, 6'h1f}; vecs[13] = '{4'hd, 6'h1f};
    vecs[14] = '{4'he, 6'h1f}; vecs[15] = '{4'hf, 6'h1f};

    // Outputs quiet during reset even with requests and an exception present
    rst = 1'b1;
    set_req(4'hf);
    exc = 32'h08;
    epc = 32'h0;
    model_reset();
    #2;
    check("rst.stall", 32'(stall), 32'h0);
    check("rst.flush", 32'(flush), 32'h0);
    check("rst.new_pc", new_pc, 32'h0);
    set_req(4'h0);
    exc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_now("idle");
    advance();

    // Five IF stall cycles then one exception
    set_req(4'h1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("if_stall", 32'(stall), 32'h03);
      advance();
    end
    set_req(4'h0);
    exc = 32'h08;
    #1;
    expect_now("cnt_freeze");
    advance();
    exc = 32'h0;
    #1;
    expect_now("cnt_flush");
    advance();
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("cnt_after_flush", stall_cycles, 32'd6);
`endif

    // Table of all request combinations in RUN
    for (int i = 0; i < 16; i++) begin
      set_req(vecs[i].req);
      exc = 32'h0;
      #1;
      check($sformatf("tbl[%0d]", i), 32'(stall), 32'(vecs[i].exp));
      advance();
    end

    // Same-cycle response when EX drops
    set_req(4'b0110);
    #1;
    check("id_ex", 32'(stall), 32'h0f);
    set_req(4'b0010);
    #1;
    check("id_only", 32'(stall), 32'h07);
    advance();
    set_req(4'h0);

    // Syscall held for two cycles
    exc = 32'h08;
    #1;
    check("sys.c1.stall", 32'(stall), 32'h3f);
    check("sys.c1.flush", 32'(flush), 32'h0);
    advance();
    #1;
    check("sys.c2.flush", 32'(flush), 32'h1);
    check("sys.c2.new_pc", new_pc, 32'h20);
    check("sys.c2.stall", 32'(stall), 32'h0);
    advance();
    exc = 32'h0;
    #1;
    check("sys.c3.flush", 32'(flush), 32'h0);
    check("sys.c3.new_pc", new_pc, 32'h0);
    advance();

    // ERET with a MEM request that must be ignored
    exc = 32'h0e;
    epc = 32'h0000_1234;
    set_req(4'h8);
    #1;
    check("eret.c1.stall", 32'(stall), 32'h3f);
    check("eret.c1.flush", 32'(flush), 32'h0);
    advance();
    #1;
    check("eret.c2.flush", 32'(flush), 32'h1);
    check("eret.c2.new_pc", new_pc, 32'h1234);
    check("eret.c2.stall", 32'(stall), 32'h0);
    advance();
    exc = 32'h0;
    set_req(4'h0);
    #1;
    expect_now("eret.c3");
    advance();

    // Asynchronous reset mid-freeze
    exc = 32'h08;
    #1;
    check("arst.freeze", 32'(stall), 32'h3f);
    #1;
    rst = 1'b1;
    #1;
    check("arst.stall", 32'(stall), 32'h0);
    check("arst.flush", 32'(flush), 32'h0);
    check("arst.new_pc", new_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    exc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst.noflush", 32'(flush), 32'h0);
    check("arst.new_pc2", new_pc, 32'h0);
    expect_now("arst.after");
    advance();

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      set_req(4'($urandom));
      exc = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      epc = $urandom;
      #1;
      expect_now("rnd");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
